ysyx_22041211_ifu: RTL and testbench

Instruction fetch unit for the NPC core. It holds the architectural PC and presents it on pc_cur to the PC+4 adder stage, taking the sequential address back on pc_seq. It issues one instruction-memory request per instruction over a valid/ready request channel with a separate response channel, then delivers the instruction, together with its PC, to the decode stage through a valid/ready handshake. It also handles redirects from branch and jump resolution, including squashing in-flight fetches.

---
 rtl/ysyx_22041211_ifu_if.sv | 36 +++
 rtl/ysyx_22041211_ifu.sv | 125 ++++++++++++
 tb/tb_ysyx_22041211_ifu.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041211_ifu_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channels and the
// instruction handshake towards decode.
//   imem_req_valid/addr/ready  : fetch request (valid/ready)
//   imem_resp_valid/data       : fetch response (single-cycle pulse)
//   inst_valid/inst/inst_pc    : fetched instruction to decode
//   inst_ready                 : decode accepts the instruction
// master = fetch unit side, slave = memory/decode side.
interface ysyx_22041211_ifu_if #(
   parameter int unsigned DATA_LEN = 32
);
   logic                imem_req_valid;
   logic [DATA_LEN-1:0] imem_req_addr;
   logic                imem_req_ready;
   logic                imem_resp_valid;
   logic [DATA_LEN-1:0] imem_resp_data;
   logic                inst_valid;
   logic [DATA_LEN-1:0] inst;
   logic [DATA_LEN-1:0] inst_pc;
   logic                inst_ready;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid, imem_resp_data,
      output inst_valid, inst, inst_pc,
      input  inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid, imem_resp_data,
      input  inst_valid, inst, inst_pc,
      output inst_ready
   );
endinterface

// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit: holds the PC, issues one memory request per
// instruction, hands the instruction to decode and squashes fetches on redirect.
//   clk, rst       : clock, synchronous active-high reset
//   pc_cur         : current PC to the PC+4 adder
//   pc_seq         : sequential PC from the adder
//   redirect_valid : taken branch/jump pulse, redirect_pc is the target
//   bus            : memory request/response and decode handshake bundle
//   fetch_cnt      : instructions delivered to decode (wraps)
module ysyx_22041211_ifu #(
   parameter int unsigned         DATA_LEN = 32,
   parameter logic [DATA_LEN-1:0] RESET_PC = 'h8000_0000
) (
   input  logic                clk,
   input  logic                rst,
   output logic [DATA_LEN-1:0] pc_cur,
   input  logic [DATA_LEN-1:0] pc_seq,
   input  logic                redirect_valid,
   input  logic [DATA_LEN-1:0] redirect_pc,
   ysyx_22041211_ifu_if.master bus,
   output logic [31:0]         fetch_cnt
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_LEN-1:0] pc_q, pc_d;
   logic                kill_q, kill_d;
   logic                inst_valid_q, inst_valid_d;
   logic [DATA_LEN-1:0] inst_q, inst_d;
   logic [DATA_LEN-1:0] inst_pc_q, inst_pc_d;
   logic [31:0]         fetch_cnt_q, fetch_cnt_d;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         kill_q       <= 1'b0;
         inst_valid_q <= 1'b0;
         inst_q       <= '0;
         inst_pc_q    <= '0;
         fetch_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         kill_q       <= kill_d;
         inst_valid_q <= inst_valid_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         fetch_cnt_q  <= fetch_cnt_d;
      end
   end

   // Next-state logic; the redirect block at the end overrides the normal flow
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      kill_d       = kill_q;
      inst_valid_d = inst_valid_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      fetch_cnt_d  = fetch_cnt_q;

      unique case (state_q)
         S_REQ: begin
            if (bus.imem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.imem_resp_valid) begin
               // A redirect in the same cycle squashes this response too
               if (kill_q || redirect_valid) begin
                  kill_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  inst_d       = bus.imem_resp_data;
                  inst_pc_d    = pc_q;
                  inst_valid_d = 1'b1;
                  state_d      = S_OUT;
               end
            end
         end
         S_OUT: begin
            if (bus.inst_ready) begin
               inst_valid_d = 1'b0;
               pc_d         = pc_seq;
               fetch_cnt_d  = fetch_cnt_q + 32'd1;
               state_d      = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase

      if (redirect_valid) begin
         pc_d = redirect_pc & ~DATA_LEN'(3);
         unique case (state_q)
            S_REQ: begin
               // Request leaving now targets the old PC; squash its response
               if (bus.imem_req_ready) kill_d = 1'b1;
            end
            S_WAIT: begin
               if (!bus.imem_resp_valid) kill_d = 1'b1;
            end
            S_OUT: begin
               // A same-cycle handshake still counts (handled above)
               inst_valid_d = 1'b0;
               state_d      = S_REQ;
            end
            default: ;
         endcase
      end
   end

   assign pc_cur             = pc_q;
   assign bus.imem_req_valid = !rst && (state_q == S_REQ);
   assign bus.imem_req_addr  = pc_q;
   assign bus.inst_valid     = inst_valid_q;
   assign bus.inst           = inst_q;
   assign bus.inst_pc        = inst_pc_q;
   assign fetch_cnt          = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Directed bench for the fetch unit: expected instructions are queued when the
// memory response is driven and compared when decode accepts them.
module tb_ysyx_22041211_ifu;

   localparam int unsigned DATA_LEN = 32;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_cur;
   logic [31:0] pc_seq;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] fetch_cnt;

   int n_total = 0;
   int n_pass  = 0;
   exp_t sb[$];

   ysyx_22041211_ifu_if #(.DATA_LEN(DATA_LEN)) bus ();

   ysyx_22041211_ifu #(
      .DATA_LEN(DATA_LEN),
      .RESET_PC(32'h8000_0000)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_cur        (pc_cur),
      .pc_seq        (pc_seq),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .bus           (bus),
      .fetch_cnt     (fetch_cnt)
   );

   always #5 clk = ~clk;

   // PC+4 adder stage
   assign pc_seq = pc_cur + 32'd4;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue a request at exp_addr, answer it one cycle later with data
   task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data, input bit push);
      exp_t e;
      check("req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("req_addr", bus.imem_req_addr, exp_addr);
      bus.imem_req_ready = 1'b1;
      step();
      bus.imem_req_ready = 1'b0;
      check("req_idle_wait", 32'(bus.imem_req_valid), 32'd0);
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = data;
      if (push) begin
         e.inst = data;
         e.pc   = exp_addr;
         sb.push_back(e);
      end
      step();
      bus.imem_resp_valid = 1'b0;
   endtask

   task automatic accept();
      bus.inst_ready = 1'b1;
      step();
      bus.inst_ready = 1'b0;
   endtask

   // Scoreboard: compare every instruction decode accepts
   always @(negedge clk) begin
      if (!rst && bus.inst_valid) begin
         check("no_stale", 32'(bus.inst == 32'hDEAD_BEEF), 32'd0);
         if (bus.inst_ready) begin
            if (sb.size() == 0) begin
               check("sb_unexpected", bus.inst, 32'hXXXX_XXXX);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("sb_inst", bus.inst, e.inst);
               check("sb_pc", bus.inst_pc, e.pc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst                 = 1'b1;
      redirect_valid      = 1'b0;
      redirect_pc         = '0;
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
      bus.inst_ready      = 1'b0;
      step();
      step();
      check("rst_pc", pc_cur, 32'h8000_0000);
      check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      check("rst_inst", bus.inst, 32'd0);
      check("rst_inst_pc", bus.inst_pc, 32'd0);
      check("rst_cnt", fetch_cnt, 32'd0);
      rst = 1'b0;
      #1;

      // Basic fetch and delivery
      do_fetch(32'h8000_0000, 32'h0000_0413, 1'b1);
      check("t1_inst_valid", 32'(bus.inst_valid), 32'd1);
      check("t1_inst", bus.inst, 32'h0000_0413);
      check("t1_inst_pc", bus.inst_pc, 32'h8000_0000);
      accept();
      check("t1_cnt", fetch_cnt, 32'd1);

      // Decode stall holds the instruction
      do_fetch(32'h8000_0004, 32'h0010_0093, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step();
         check("t2_hold_valid", 32'(bus.inst_valid), 32'd1);
         check("t2_hold_inst", bus.inst, 32'h0010_0093);
         check("t2_hold_pc", bus.inst_pc, 32'h8000_0004);
         check("t2_hold_req", 32'(bus.imem_req_valid), 32'd0);
         check("t2_hold_pccur", pc_cur, 32'h8000_0004);
      end
      accept();
      check("t2_pc_next", pc_cur, 32'h8000_0008);
      check("t2_cnt", fetch_cnt, 32'd2);

      // Redirect while waiting: response squashed
      check("t3_req_addr", bus.imem_req_addr, 32'h8000_0008);
      bus.imem_req_ready = 1'b1;
      step();
      bus.imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0103;
      step();
      redirect_valid = 1'b0;
      check("t3_pc_align", pc_cur, 32'h8000_0100);
      check("t3_req_idle", 32'(bus.imem_req_valid), 32'd0);
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'hDEAD_BEEF;
      step();
      bus.imem_resp_valid = 1'b0;
      check("t3_no_valid", 32'(bus.inst_valid), 32'd0);
      do_fetch(32'h8000_0100, 32'h0000_0013, 1'b1);
      accept();
      check("t3_cnt", fetch_cnt, 32'd3);

      // Redirect in S_REQ, not accepted: new address next cycle
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0040;
      step();
      redirect_valid = 1'b0;
      check("t3b_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("t3b_req_addr", bus.imem_req_addr, 32'h8000_0040);

      // Redirect in S_REQ, accepted same cycle: old request squashed
      redirect_valid     = 1'b1;
      redirect_pc        = 32'h8000_0010;
      bus.imem_req_ready = 1'b1;
      step();
      redirect_valid     = 1'b0;
      bus.imem_req_ready = 1'b0;
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'hDEAD_BEEF;
      step();
      bus.imem_resp_valid = 1'b0;
      check("t3c_no_valid", 32'(bus.inst_valid), 32'd0);

      // Redirect together with a decode handshake
      do_fetch(32'h8000_0010, 32'h0020_0113, 1'b1);
      bus.inst_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0200;
      step();
      bus.inst_ready = 1'b0;
      redirect_valid = 1'b0;
      check("t4_cnt", fetch_cnt, 32'd4);
      check("t4_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("t4_req_addr", bus.imem_req_addr, 32'h8000_0200);

      // Redirect in S_OUT without handshake: instruction discarded
      do_fetch(32'h8000_0200, 32'h0030_0193, 1'b0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0300;
      step();
      redirect_valid = 1'b0;
      check("t4b_inst_valid", 32'(bus.inst_valid), 32'd0);
      check("t4b_cnt", fetch_cnt, 32'd4);
      check("t4b_req_addr", bus.imem_req_addr, 32'h8000_0300);

      // Reset while waiting, then a stale response
      bus.imem_req_ready = 1'b1;
      step();
      bus.imem_req_ready = 1'b0;
      rst = 1'b1;
      step();
      check("t5_rst_req", 32'(bus.imem_req_valid), 32'd0);
      check("t5_rst_pc", pc_cur, 32'h8000_0000);
      rst = 1'b0;
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'hDEAD_BEEF;
      step();
      bus.imem_resp_valid = 1'b0;
      check("t5_inst_valid", 32'(bus.inst_valid), 32'd0);
      check("t5_cnt", fetch_cnt, 32'd0);

      // Counter wrap
      do_fetch(32'h8000_0000, 32'h0000_0513, 1'b1);
      force dut.fetch_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.fetch_cnt_q;
      check("t6_preload", fetch_cnt, 32'hFFFF_FFFF);
      accept();
      check("t6_wrap", fetch_cnt, 32'd0);
      check("t6_pc", pc_cur, 32'h8000_0004);

      step();
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
